// File: rtl/vit_pkg.sv
// vit_pkg: shared state encoding and parameter defaults for the Viterbi decoder control path.
package vit_pkg;
    localparam int TB_LEN_DEF = 16;
    localparam int ADDR_W_DEF = 6;
    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DRAIN} vit_state_e;
endpackage

// File: rtl/vit_ring_ptr.sv
// vit_ring_ptr: modulo-2**W write pointer with synchronous clear.
module vit_ring_ptr #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] ptr
);
    always_ff @(posedge clk)
        if (clr) ptr <= '0;
        else if (inc) ptr <= ptr + 1'b1;
endmodule

// File: rtl/vit_ctrl.sv
// vit_ctrl: Viterbi decoder sequencer driving branch metrics, ACS, survivor writes and traceback.
// Optional VIT_CTRL_STATS_EN adds sym_count/tb_count statistics outputs.
module vit_ctrl
    import vit_pkg::*;
#(
    parameter int TB_LEN = TB_LEN_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic                          in_last,
    input  logic [1:0]                    rx_pair,
    output logic                          in_ready,
    output logic [1:0]                    bmc_rx_pair,
    output logic                          acs_en,
    output logic                          pm_init,
    output logic                          sm_wr_en,
    output logic [ADDR_W-1:0]             sm_wr_addr,
    output logic                          tb_start,
    output logic                          tb_flush,
    output logic [ADDR_W-1:0]             tb_addr,
    output logic [$clog2(TB_LEN+1)-1:0]   tb_depth,
    input  logic                          tb_busy,
    output logic                          frame_done
`ifdef VIT_CTRL_STATS_EN
    ,
    output logic [15:0]                   sym_count,
    output logic [15:0]                   tb_count
`endif
);
    localparam int DW = $clog2(TB_LEN + 1);

    vit_state_e        r_state;
    logic [DW-1:0]     r_cnt;
    logic [DW-1:0]     w_cnt_nxt;
    logic [ADDR_W-1:0] w_wr_ptr;
    logic              w_acc;
    logic              w_tb_run;
    logic              w_tb_fl;
    logic              w_done;

    assign in_ready  = (r_state == IDLE || r_state == RUN) && !tb_busy && !tb_start;
    assign w_acc     = in_valid && in_ready;
    assign w_cnt_nxt = (r_cnt == DW'(TB_LEN)) ? r_cnt : r_cnt + 1'b1;
    assign w_tb_run  = w_acc && !in_last && r_state == RUN && w_cnt_nxt == DW'(TB_LEN);
    // tb_busy lags tb_start by a cycle, so a live tb_start also blocks the flush launch
    assign w_tb_fl   = r_state == FLUSH && !tb_busy && !tb_start;
    assign w_done    = r_state == DRAIN && !tb_start && !tb_busy;

    vit_ring_ptr #(.W(ADDR_W)) u_ptr (
        .clk (clk),
        .inc (w_acc),
        .clr (rst),
        .ptr (w_wr_ptr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            bmc_rx_pair <= '0;
            acs_en      <= 1'b0;
            pm_init     <= 1'b0;
            sm_wr_en    <= 1'b0;
            sm_wr_addr  <= '0;
            tb_start    <= 1'b0;
            tb_flush    <= 1'b0;
            tb_addr     <= '0;
            tb_depth    <= '0;
            frame_done  <= 1'b0;
        end else begin
            acs_en     <= w_acc;
            sm_wr_en   <= w_acc;
            pm_init    <= w_acc && r_state == IDLE;
            tb_start   <= w_tb_run || w_tb_fl;
            tb_flush   <= w_tb_fl;
            frame_done <= w_done;
            if (w_acc) begin
                bmc_rx_pair <= rx_pair;
                sm_wr_addr  <= w_wr_ptr;
                r_cnt       <= w_cnt_nxt;
            end else if (w_done) begin
                r_cnt <= '0;
            end
            if (w_tb_run) begin
                tb_addr  <= w_wr_ptr;
                tb_depth <= DW'(TB_LEN);
            end else if (w_tb_fl) begin
                tb_addr  <= sm_wr_addr;
                tb_depth <= r_cnt;
            end
            if (w_acc) r_state <= in_last ? FLUSH : RUN;
            else if (w_tb_fl) r_state <= DRAIN;
            else if (w_done) r_state <= IDLE;
        end
    end

`ifdef VIT_CTRL_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            sym_count <= '0;
            tb_count  <= '0;
        end else begin
            if (w_acc) sym_count <= (r_state == IDLE) ? 16'd1 : (sym_count == 16'hFFFF) ? sym_count : sym_count + 1'b1;
            if (w_tb_run || w_tb_fl) tb_count <= tb_count + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_vit_ctrl.sv
// tb_vit_ctrl: directed table and sequence checks for vit_ctrl with TB_LEN=4, ADDR_W=3.
module tb_vit_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0, in_last = 1'b0, tb_busy = 1'b0;
    logic [1:0] rx_pair = '0;
    logic       in_ready, acs_en, pm_init, sm_wr_en, tb_start, tb_flush, frame_done;
    logic [1:0] bmc_rx_pair;
    logic [2:0] sm_wr_addr, tb_addr, tb_depth;
`ifdef VIT_CTRL_STATS_EN
    logic [15:0] sym_count, tb_count;
`endif

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        bit chk, rst, v, l;
        bit [1:0] pr;
        bit bsy, rdy, acs, pm;
        bit [2:0] addr;
        bit [1:0] bp;
        bit tbs, tbf;
        bit [2:0] tba, tbd;
        bit done;
    } vec_t;

    vec_t tv[$];
    int wr_addr_q[$], wr_pair_q[$], wr_pm_q[$], tbs_q[$];
    int busy_viol;

    vit_ctrl #(.TB_LEN(4), .ADDR_W(3)) dut (
        .clk (clk), .rst (rst), .in_valid (in_valid), .in_last (in_last), .rx_pair (rx_pair),
        .in_ready (in_ready), .bmc_rx_pair (bmc_rx_pair), .acs_en (acs_en), .pm_init (pm_init),
        .sm_wr_en (sm_wr_en), .sm_wr_addr (sm_wr_addr), .tb_start (tb_start), .tb_flush (tb_flush),
        .tb_addr (tb_addr), .tb_depth (tb_depth), .tb_busy (tb_busy), .frame_done (frame_done)
`ifdef VIT_CTRL_STATS_EN
        , .sym_count (sym_count), .tb_count (tb_count)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input int c, r, v, l, pr, b, rdy, acs, pm, addr, bp, tbs, tbf, tba, tbd, done);
        vec_t m;
        m.chk = c[0]; m.rst = r[0]; m.v = v[0]; m.l = l[0]; m.pr = pr[1:0]; m.bsy = b[0];
        m.rdy = rdy[0]; m.acs = acs[0]; m.pm = pm[0]; m.addr = addr[2:0]; m.bp = bp[1:0];
        m.tbs = tbs[0]; m.tbf = tbf[0]; m.tba = tba[2:0]; m.tbd = tbd[2:0]; m.done = done[0];
        return m;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; tb_busy = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // tb_busy follows each observed tb_start for blen cycles, like a traceback unit would
    task automatic run_frame(input int n, input int blen, input int max_cyc);
        int sent = 0;
        int bcnt = 0;
        int cyc = 0;
        bit done = 0;
        wr_addr_q.delete(); wr_pair_q.delete(); wr_pm_q.delete(); tbs_q.delete();
        busy_viol = 0;
        while (!done && cyc < max_cyc) begin
            @(negedge clk);
            tb_busy  = (bcnt > 0);
            in_valid = (sent < n);
            in_last  = (sent == n - 1);
            rx_pair  = 2'((sent * 3 + 1) % 4);
            #1;
            if (tb_busy && in_ready) busy_viol++;
            if (in_valid && in_ready) sent++;
            if (sm_wr_en) begin
                wr_addr_q.push_back(int'(sm_wr_addr));
                wr_pair_q.push_back(int'(bmc_rx_pair));
                wr_pm_q.push_back(int'(pm_init));
            end
            if (tb_start) tbs_q.push_back(int'(tb_flush) * 100 + int'(tb_addr) * 10 + int'(tb_depth));
            if (tb_start) bcnt = blen;
            else if (bcnt > 0) bcnt--;
            if (frame_done) done = 1;
            cyc++;
        end
        in_valid = 1'b0; in_last = 1'b0; tb_busy = 1'b0;
        chk("frame_done_seen", int'(done), 1);
    endtask

    initial begin
        int ea24[10] = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1};
        int et24[7]  = '{34, 44, 54, 64, 74, 4, 114};
        int et23[2]  = '{34, 144};
        // reset / sequence A: six-pair frame, no busy
        tv.push_back(mk(0,1,0,0,0,0, 0,0,0,0,0, 0,0,0,0, 0));
        tv.push_back(mk(1,0,1,0,1,0, 1,0,0,0,0, 0,0,0,0, 0));
        tv.push_back(mk(1,0,1,0,2,0, 1,1,1,0,1, 0,0,0,0, 0));
        tv.push_back(mk(1,0,1,0,3,0, 1,1,0,1,2, 0,0,0,0, 0));
        tv.push_back(mk(1,0,1,0,0,0, 1,1,0,2,3, 0,0,0,0, 0));
        tv.push_back(mk(1,0,1,0,3,0, 0,1,0,3,0, 1,0,3,4, 0));
        tv.push_back(mk(1,0,1,0,1,0, 1,0,0,0,0, 0,0,0,0, 0));
        tv.push_back(mk(1,0,1,1,2,0, 0,1,0,4,1, 1,0,4,4, 0));
        tv.push_back(mk(1,0,1,1,2,0, 1,0,0,0,0, 0,0,0,0, 0));
        tv.push_back(mk(1,0,1,0,3,0, 0,1,0,5,2, 0,0,0,0, 0));
        tv.push_back(mk(1,0,0,0,0,0, 0,0,0,0,0, 1,1,5,4, 0));
        tv.push_back(mk(1,0,0,0,0,0, 0,0,0,0,0, 0,0,0,0, 0));
        tv.push_back(mk(1,0,0,0,0,0, 1,0,0,0,0, 0,0,0,0, 1));
        tv.push_back(mk(1,0,0,0,0,0, 1,0,0,0,0, 0,0,0,0, 0));
        // sequence B: single-pair frame
        tv.push_back(mk(0,1,0,0,0,0, 0,0,0,0,0, 0,0,0,0, 0));
        tv.push_back(mk(1,0,1,1,3,0, 1,0,0,0,0, 0,0,0,0, 0));
        tv.push_back(mk(1,0,0,0,0,0, 0,1,1,0,3, 0,0,0,0, 0));
        tv.push_back(mk(1,0,0,0,0,0, 0,0,0,0,0, 1,1,0,1, 0));
        tv.push_back(mk(1,0,0,0,0,0, 0,0,0,0,0, 0,0,0,0, 0));
        tv.push_back(mk(1,0,0,0,0,0, 1,0,0,0,0, 0,0,0,0, 1));
        // sequence C: reset on the third pair, then a fresh frame
        tv.push_back(mk(0,1,0,0,0,0, 0,0,0,0,0, 0,0,0,0, 0));
        tv.push_back(mk(1,0,1,0,1,0, 1,0,0,0,0, 0,0,0,0, 0));
        tv.push_back(mk(1,0,1,0,2,0, 1,1,1,0,1, 0,0,0,0, 0));
        tv.push_back(mk(1,1,1,0,3,0, 1,1,0,1,2, 0,0,0,0, 0));
        for (int k = 0; k < 4; k++) tv.push_back(mk(1,0,0,0,0,0, 1,0,0,0,0, 0,0,0,0, 0));
        tv.push_back(mk(1,0,1,0,2,0, 1,0,0,0,0, 0,0,0,0, 0));
        tv.push_back(mk(1,0,0,0,0,0, 1,1,1,0,2, 0,0,0,0, 0));

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_acs_en", int'(acs_en), 0);
        chk("rst_sm_wr_en", int'(sm_wr_en), 0);
        chk("rst_pm_init", int'(pm_init), 0);
        chk("rst_wr_addr", int'(sm_wr_addr), 0);
        chk("rst_bmc_pair", int'(bmc_rx_pair), 0);
        chk("rst_tb_start", int'(tb_start), 0);
        chk("rst_tb_flush", int'(tb_flush), 0);
        chk("rst_tb_addr", int'(tb_addr), 0);
        chk("rst_tb_depth", int'(tb_depth), 0);
        chk("rst_frame_done", int'(frame_done), 0);

        foreach (tv[i]) begin
            @(negedge clk);
            rst = tv[i].rst; in_valid = tv[i].v; in_last = tv[i].l; rx_pair = tv[i].pr; tb_busy = tv[i].bsy;
            #1;
            if (tv[i].chk) begin
                chk($sformatf("row%0d_in_ready", i), int'(in_ready), int'(tv[i].rdy));
                chk($sformatf("row%0d_acs_en", i), int'(acs_en), int'(tv[i].acs));
                chk($sformatf("row%0d_sm_wr_en", i), int'(sm_wr_en), int'(tv[i].acs));
                chk($sformatf("row%0d_pm_init", i), int'(pm_init), int'(tv[i].pm));
                chk($sformatf("row%0d_tb_start", i), int'(tb_start), int'(tv[i].tbs));
                chk($sformatf("row%0d_frame_done", i), int'(frame_done), int'(tv[i].done));
                if (tv[i].acs) begin
                    chk($sformatf("row%0d_wr_addr", i), int'(sm_wr_addr), int'(tv[i].addr));
                    chk($sformatf("row%0d_bmc_pair", i), int'(bmc_rx_pair), int'(tv[i].bp));
                end
                if (tv[i].tbs) begin
                    chk($sformatf("row%0d_tb_flush", i), int'(tb_flush), int'(tv[i].tbf));
                    chk($sformatf("row%0d_tb_addr", i), int'(tb_addr), int'(tv[i].tba));
                    chk($sformatf("row%0d_tb_depth", i), int'(tb_depth), int'(tv[i].tbd));
                end
            end
        end
        rst = 1'b0; in_valid = 1'b0;

        // five-pair frame with tb_busy held 5 cycles after every tb_start
        do_reset();
        run_frame(5, 5, 200);
        chk("busy_in_ready_viol", busy_viol, 0);
        chk("busy_wr_count", wr_addr_q.size(), 5);
        for (int k = 0; k < 5 && k < wr_addr_q.size(); k++) begin
            chk($sformatf("busy_wr%0d_addr", k), wr_addr_q[k], k);
            chk($sformatf("busy_wr%0d_pair", k), wr_pair_q[k], (k * 3 + 1) % 4);
            chk($sformatf("busy_wr%0d_pm", k), wr_pm_q[k], (k == 0) ? 1 : 0);
        end
        chk("busy_tbs_count", tbs_q.size(), 2);
        for (int k = 0; k < 2 && k < tbs_q.size(); k++) chk($sformatf("busy_tbs%0d", k), tbs_q[k], et23[k]);

        // ten-pair frame wrapping the 3-bit address space
        do_reset();
        run_frame(10, 0, 200);
        chk("wrap_wr_count", wr_addr_q.size(), 10);
        for (int k = 0; k < 10 && k < wr_addr_q.size(); k++) begin
            chk($sformatf("wrap_wr%0d_addr", k), wr_addr_q[k], ea24[k]);
            chk($sformatf("wrap_wr%0d_pair", k), wr_pair_q[k], (k * 3 + 1) % 4);
        end
        chk("wrap_tbs_count", tbs_q.size(), 7);
        for (int k = 0; k < 7 && k < tbs_q.size(); k++) chk($sformatf("wrap_tbs%0d", k), tbs_q[k], et24[k]);
`ifdef VIT_CTRL_STATS_EN
        chk("stats_sym_count", int'(sym_count), 10);
        chk("stats_tb_count", int'(tb_count), 7);
`endif

        // next frame keeps counting addresses from where the last one ended
        run_frame(1, 0, 50);
        chk("cont_wr_count", wr_addr_q.size(), 1);
        if (wr_addr_q.size() > 0) begin
            chk("cont_wr_addr", wr_addr_q[0], 2);
            chk("cont_pm_init", wr_pm_q[0], 1);
        end
        chk("cont_tbs_count", tbs_q.size(), 1);
        if (tbs_q.size() > 0) chk("cont_tbs", tbs_q[0], 121);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
